// File: rtl/uart_frame_pkg.sv
// rtl/uart_frame_pkg.sv - shared framer definitions: FSM encoding, sync byte, checksum step
package uart_frame_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } frame_state_e;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
    localparam int unsigned CSUM_MAX_BITS    = 16;

    // One accumulation step of the frame checksum; the deframer calls the same function.
    function automatic logic [CSUM_MAX_BITS-1:0] checksum_add(
        input logic [CSUM_MAX_BITS-1:0] acc,
        input logic [CSUM_MAX_BITS-1:0] data,
        input int unsigned              bits
    );
        logic [CSUM_MAX_BITS:0]   sum;
        logic [CSUM_MAX_BITS-1:0] mask;
        sum  = {1'b0, acc} + {1'b0, data};
        mask = (16'h1 << bits) - 16'h1;
        return sum[CSUM_MAX_BITS-1:0] & mask;
    endfunction

endpackage

// File: rtl/uart_frame_tx.sv
// rtl/uart_frame_tx.sv - word-to-byte-stream framer driving uart_tx through its en/busy handshake
module uart_frame_tx
    import uart_frame_pkg::*;
#(
    parameter int unsigned PAYLOAD_BITS = 8,
    parameter int unsigned WORD_BYTES   = 4,
    parameter logic [7:0]  SYNC_BYTE    = SYNC_BYTE_DEFAULT,
    parameter bit          CHECKSUM_EN  = 1'b1
) (
    input  logic                               clk,
    input  logic                               resetn,
    input  logic                               word_valid,
    output logic                               word_ready,
    input  logic [WORD_BYTES*PAYLOAD_BITS-1:0] word_data,
    output logic                               uart_tx_en,
    output logic [PAYLOAD_BITS-1:0]            uart_tx_data,
    input  logic                               uart_tx_busy,
    output logic                               frame_busy,
    output logic [15:0]                        frames_sent
);

    localparam int unsigned WORD_W   = WORD_BYTES * PAYLOAD_BITS;
    localparam int unsigned IDX_W    = $clog2(WORD_BYTES + 3);
    localparam int unsigned LAST_IDX = WORD_BYTES + (CHECKSUM_EN ? 1 : 0);

    frame_state_e              state_q;
    logic [WORD_W-1:0]         shreg_q;
    logic [IDX_W-1:0]          byte_idx_q;
    logic [PAYLOAD_BITS-1:0]   csum_q;
    logic                      word_ready_q;
    logic                      tx_en_q;
    logic [PAYLOAD_BITS-1:0]   tx_data_q;
    logic                      frame_busy_q;
    logic [15:0]               frames_q;

    logic [PAYLOAD_BITS-1:0]   cur_byte;
    logic                      cur_is_data;
    logic                      cur_is_last;

    // Index 0 is the sync byte, 1..WORD_BYTES the data, the one after that the checksum.
    always_comb begin
        cur_byte    = shreg_q[PAYLOAD_BITS-1:0];
        cur_is_data = (byte_idx_q != '0) && (byte_idx_q <= IDX_W'(WORD_BYTES));
        cur_is_last = (byte_idx_q == IDX_W'(LAST_IDX));
        if (byte_idx_q == '0) begin
            cur_byte = PAYLOAD_BITS'(SYNC_BYTE);
        end else if (!cur_is_data) begin
            cur_byte = csum_q;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            shreg_q      <= '0;
            byte_idx_q   <= '0;
            csum_q       <= '0;
            word_ready_q <= 1'b1;
            tx_en_q      <= 1'b0;
            tx_data_q    <= '0;
            frame_busy_q <= 1'b0;
            frames_q     <= '0;
        end else begin
            tx_en_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (word_valid && word_ready_q) begin
                        shreg_q      <= word_data;
                        csum_q       <= '0;
                        byte_idx_q   <= '0;
                        word_ready_q <= 1'b0;
                        frame_busy_q <= 1'b1;
                        state_q      <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (!uart_tx_busy) begin
                        tx_en_q   <= 1'b1;
                        tx_data_q <= cur_byte;
                        if (cur_is_data) begin
                            shreg_q <= shreg_q >> PAYLOAD_BITS;
                            csum_q  <= PAYLOAD_BITS'(checksum_add(16'(csum_q), 16'(cur_byte),
                                                                  PAYLOAD_BITS));
                        end
                        state_q <= WAIT_BUSY;
                    end
                end
                WAIT_BUSY: begin
                    if (uart_tx_busy) begin
                        state_q <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (!uart_tx_busy) begin
                        if (cur_is_last) begin
                            frames_q     <= frames_q + 16'd1;
                            word_ready_q <= 1'b1;
                            frame_busy_q <= 1'b0;
                            state_q      <= IDLE;
                        end else begin
                            byte_idx_q <= byte_idx_q + 1'b1;
                            state_q    <= ISSUE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign word_ready   = word_ready_q;
    assign uart_tx_en   = tx_en_q;
    assign uart_tx_data = tx_data_q;
    assign frame_busy   = frame_busy_q;
    assign frames_sent  = frames_q;

endmodule

// File: tb/tb_uart_frame_tx.sv
// tb/tb_uart_frame_tx.sv - scoreboard bench: framer with checksum (ch0) and without (ch1) on a uart_tx busy model
module tb_uart_frame_tx;

    localparam int BUSY_CYC = 12;
    localparam int TMO      = 3000;

    logic        clk;
    logic        resetn;
    logic [1:0]  wvalid;
    logic [31:0] wdata [2];
    logic        wready [2];
    logic        en [2];
    logic [7:0]  txd [2];
    logic        fbusy [2];
    logic [15:0] fsent [2];
    logic [1:0]  mbusy;
    logic [1:0]  force_busy;
    logic [1:0]  txbusy;
    int          mcnt [2];

    assign txbusy = mbusy | force_busy;

    uart_frame_tx #(.PAYLOAD_BITS(8), .WORD_BYTES(4), .SYNC_BYTE(8'hA5), .CHECKSUM_EN(1'b1)) u_dut0 (
        .clk(clk), .resetn(resetn), .word_valid(wvalid[0]), .word_ready(wready[0]),
        .word_data(wdata[0]), .uart_tx_en(en[0]), .uart_tx_data(txd[0]),
        .uart_tx_busy(txbusy[0]), .frame_busy(fbusy[0]), .frames_sent(fsent[0])
    );

    uart_frame_tx #(.PAYLOAD_BITS(8), .WORD_BYTES(4), .SYNC_BYTE(8'hA5), .CHECKSUM_EN(1'b0)) u_dut1 (
        .clk(clk), .resetn(resetn), .word_valid(wvalid[1]), .word_ready(wready[1]),
        .word_data(wdata[1]), .uart_tx_en(en[1]), .uart_tx_data(txd[1]),
        .uart_tx_busy(txbusy[1]), .frame_busy(fbusy[1]), .frames_sent(fsent[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // uart_tx stand-in: busy rises the edge after en and stays high BUSY_CYC cycles.
    always @(posedge clk or negedge resetn) begin
        for (int c = 0; c < 2; c++) begin
            if (!resetn) begin
                mbusy[c] <= 1'b0;
                mcnt[c]  <= 0;
            end else if (en[c] && !mbusy[c]) begin
                mbusy[c] <= 1'b1;
                mcnt[c]  <= BUSY_CYC;
            end else if (mcnt[c] != 0) begin
                mcnt[c] <= mcnt[c] - 1;
                if (mcnt[c] == 1) mbusy[c] <= 1'b0;
            end
        end
    end

    logic [7:0] exp_q0 [$];
    logic [7:0] exp_q1 [$];
    int         en_cnt [2];
    logic [1:0] seen_rise;
    logic [1:0] prev_busy;

    initial begin
        en_cnt[0] = 0;
        en_cnt[1] = 0;
    end

    task automatic push_exp(input int c, input logic [7:0] b);
        if (c == 0) exp_q0.push_back(b);
        else        exp_q1.push_back(b);
    endtask

    task automatic push_frame(input int c, input logic [31:0] w);
        logic [7:0] sum;
        logic [7:0] b;
        sum = 8'h00;
        push_exp(c, 8'hA5);
        for (int i = 0; i < 4; i++) begin
            b   = w[8*i +: 8];
            sum = sum + b;
            push_exp(c, b);
        end
        if (c == 0) push_exp(c, sum);
    endtask

    function automatic int qsize(input int c);
        return (c == 0) ? exp_q0.size() : exp_q1.size();
    endfunction

    always @(negedge clk) begin
        if (!resetn) begin
            seen_rise = 2'b11;
            prev_busy = 2'b00;
        end else begin
            for (int c = 0; c < 2; c++) begin
                logic [7:0] eb;
                if (txbusy[c] && !prev_busy[c]) seen_rise[c] = 1'b1;
                prev_busy[c] = txbusy[c];
                if (en[c]) begin
                    en_cnt[c]++;
                    check_eq("en_while_busy", {31'd0, txbusy[c]}, 32'd0);
                    check_eq("en_without_busy_rise", {31'd0, seen_rise[c]}, 32'd1);
                    check_eq("ready_during_frame", {31'd0, wready[c]}, 32'd0);
                    seen_rise[c] = 1'b0;
                    if (qsize(c) == 0) begin
                        check_eq("unexpected_byte", {24'd0, txd[c]}, 32'hFFFF_FFFF);
                    end else begin
                        eb = (c == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                        check_eq("line_byte", {24'd0, txd[c]}, {24'd0, eb});
                    end
                end
            end
        end
    end

    task automatic send_word(input int c, input logic [31:0] w, input bit lat);
        int t;
        t = 0;
        @(negedge clk);
        wdata[c]  = w;
        wvalid[c] = 1'b1;
        while (!wready[c] && t < TMO) begin
            @(negedge clk);
            t++;
        end
        check_eq("accept_ready", {31'd0, wready[c]}, 32'd1);
        push_frame(c, w);
        @(negedge clk);
        wvalid[c] = 1'b0;
        wdata[c]  = ~w;
        check_eq("ready_low_after_accept", {31'd0, wready[c]}, 32'd0);
        if (lat) begin
            @(negedge clk);
            check_eq("sync_latency", {31'd0, en[c]}, 32'd1);
        end
    endtask

    task automatic wait_frames(input int c, input logic [15:0] n);
        int t;
        t = 0;
        while (!(fsent[c] == n && !fbusy[c]) && t < TMO) begin
            @(negedge clk);
            t++;
        end
        check_eq("frames_sent", {16'd0, fsent[c]}, {16'd0, n});
        check_eq("queue_drained", qsize(c), 0);
    endtask

    task automatic check_reset_state(input int c);
        check_eq("rst_word_ready", {31'd0, wready[c]}, 32'd1);
        check_eq("rst_tx_en", {31'd0, en[c]}, 32'd0);
        check_eq("rst_tx_data", {24'd0, txd[c]}, 32'd0);
        check_eq("rst_frame_busy", {31'd0, fbusy[c]}, 32'd0);
        check_eq("rst_frames_sent", {16'd0, fsent[c]}, 32'd0);
    endtask

    initial begin
        int base;
        int t;
        wvalid     = 2'b00;
        force_busy = 2'b00;
        wdata[0]   = 32'h0;
        wdata[1]   = 32'h0;
        resetn     = 1'b1;
        #1 resetn  = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_state(0);
        check_reset_state(1);
        resetn = 1'b1;

        send_word(0, 32'h44332211, 1'b1);
        wait_frames(0, 16'd1);
        check_eq("data_hold", {24'd0, txd[0]}, 32'hAA);

        send_word(0, 32'hFFFFFFFF, 1'b1);
        wait_frames(0, 16'd2);

        send_word(1, 32'h00000000, 1'b1);
        wait_frames(1, 16'd1);
        check_eq("nocsum_byte_count", en_cnt[1], 5);
        repeat (50) @(negedge clk);
        check_eq("nocsum_no_sixth_en", en_cnt[1], 5);

        @(negedge clk);
        wdata[0]  = 32'h12345678;
        wvalid[0] = 1'b1;
        t = 0;
        while (!wready[0] && t < TMO) begin @(negedge clk); t++; end
        push_frame(0, 32'h12345678);
        @(negedge clk);
        check_eq("b2b_ready_low", {31'd0, wready[0]}, 32'd0);
        wdata[0] = 32'h9ABCDEF0;
        t = 0;
        while (!wready[0] && t < TMO) begin @(negedge clk); t++; end
        check_eq("b2b_second_after_first", {16'd0, fsent[0]}, 32'd3);
        push_frame(0, 32'h9ABCDEF0);
        @(negedge clk);
        wvalid[0] = 1'b0;
        @(negedge clk);
        check_eq("b2b_sync_latency", {31'd0, en[0]}, 32'd1);
        wait_frames(0, 16'd4);

        force_busy[0] = 1'b1;
        send_word(0, 32'hCAFE0102, 1'b0);
        base = en_cnt[0];
        repeat (100) @(negedge clk);
        check_eq("forced_busy_no_en", en_cnt[0] - base, 0);
        force_busy[0] = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("forced_busy_single_en", en_cnt[0] - base, 1);
        wait_frames(0, 16'd5);

        send_word(0, 32'h0D0C0B0A, 1'b1);
        base = en_cnt[0];
        t = 0;
        while (en_cnt[0] < base + 2 && t < TMO) begin @(posedge clk); t++; end
        @(negedge clk);
        check_eq("midframe_reached", en_cnt[0] - base, 2);
        #2 resetn = 1'b0;
        #1;
        check_reset_state(0);
        exp_q0.delete();
        exp_q1.delete();
        @(negedge clk);
        resetn = 1'b1;
        send_word(0, 32'h87654321, 1'b1);
        wait_frames(0, 16'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
